// File: rtl/dma_pcie_byp_dsc_buf.sv
// Purpose: buffer QDMA bypass-out {dsc, cidx} beats in a FWFT FIFO and issue coalesced cidx write-back requests.
// Latency: push in cycle N is visible at out_* in cycle N+1; no same-cycle pass-through.
// Backpressure: byp_rdy drops only when the registered count is full; cidx_upd_vld holds its value until cidx_upd_rdy.
// Optional build macro DMA_BYP_DSC_BUF_STATS_EN adds saturating push/pop/full-stall counters.
module dma_pcie_byp_dsc_buf #(
    parameter int DEPTH       = 16,
    parameter int COAL_THRESH = 8
) (
    input  logic                     user_clk,
    input  logic                     user_reset,
    input  logic [255:0]             byp_dsc,
    input  logic [15:0]              byp_cidx,
    input  logic                     byp_vld,
    output logic                     byp_rdy,
    output logic [255:0]             out_dsc,
    output logic [15:0]              out_cidx,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [15:0]              cidx_upd,
    output logic                     cidx_upd_vld,
    input  logic                     cidx_upd_rdy,
    output logic [$clog2(DEPTH):0]   fifo_cnt
`ifdef DMA_BYP_DSC_BUF_STATS_EN
   ,output logic [31:0]              stat_in_cnt,
    output logic [31:0]              stat_out_cnt,
    output logic [31:0]              stat_full_cyc
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [15:0]   THRESH   = 16'(COAL_THRESH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_UPD  = 1'b1
    } upd_st_t;

    // Storage entries hold {cidx, dsc} so a single read gives the whole head beat.
    logic [271:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    upd_st_t       st_q, st_d;
    logic [15:0]   cidx_upd_q, cidx_upd_d;
    logic          upd_vld_q, upd_vld_d;
    logic [15:0]   pend_q, pend_d;
    logic [15:0]   last_cidx_q, last_cidx_d;
    logic [15:0]   pend_inc;

    logic          push;
    logic          pop;

    // Ready/valid come from the registered count only, so out_rdy never reaches byp_rdy combinationally.
    assign byp_rdy               = (cnt_q != FULL_CNT);
    assign out_vld               = (cnt_q != '0);
    assign push                  = byp_vld & byp_rdy;
    assign pop                   = out_vld & out_rdy;
    assign {out_cidx, out_dsc}   = mem_q[rd_ptr_q];
    assign fifo_cnt              = cnt_q;
    assign cidx_upd              = cidx_upd_q;
    assign cidx_upd_vld          = upd_vld_q;

    // Pointer and occupancy next-state; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Descriptor storage is not reset; contents are only observed while out_vld is high.
    always_ff @(posedge user_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {byp_cidx, byp_dsc};
        end
    end

    // Coalescing next-state: a pop in the launch cycle is folded into the launched cidx, so pend restarts at 0.
    always_comb begin
        pend_inc    = (pop && (pend_q != 16'hFFFF)) ? pend_q + 16'd1 : pend_q;
        st_d        = st_q;
        cidx_upd_d  = cidx_upd_q;
        upd_vld_d   = upd_vld_q;
        pend_d      = pend_inc;
        last_cidx_d = pop ? out_cidx : last_cidx_q;
        if (st_q == ST_IDLE) begin
            if ((pend_inc >= THRESH) ||
                ((pend_q != 16'd0) && (cnt_q == '0) && !byp_vld)) begin
                st_d       = ST_UPD;
                upd_vld_d  = 1'b1;
                cidx_upd_d = pop ? out_cidx : last_cidx_q;
                pend_d     = 16'd0;
            end
        end else begin
            if (cidx_upd_rdy) begin
                st_d      = ST_IDLE;
                upd_vld_d = 1'b0;
            end
        end
    end

    // FIFO control and update FSM registers; reset drops queued beats and any outstanding update.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            st_q        <= ST_IDLE;
            cidx_upd_q  <= 16'd0;
            upd_vld_q   <= 1'b0;
            pend_q      <= 16'd0;
            last_cidx_q <= 16'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            st_q        <= st_d;
            cidx_upd_q  <= cidx_upd_d;
            upd_vld_q   <= upd_vld_d;
            pend_q      <= pend_d;
            last_cidx_q <= last_cidx_d;
        end
    end

`ifdef DMA_BYP_DSC_BUF_STATS_EN
    logic [31:0] in_cnt_q, in_cnt_d;
    logic [31:0] out_cnt_q, out_cnt_d;
    logic [31:0] full_cyc_q, full_cyc_d;

    assign stat_in_cnt   = in_cnt_q;
    assign stat_out_cnt  = out_cnt_q;
    assign stat_full_cyc = full_cyc_q;

    // Saturating event counters: pushes, pops and upstream stall cycles.
    always_comb begin
        in_cnt_d   = (push && (in_cnt_q != 32'hFFFF_FFFF)) ? in_cnt_q + 32'd1 : in_cnt_q;
        out_cnt_d  = (pop && (out_cnt_q != 32'hFFFF_FFFF)) ? out_cnt_q + 32'd1 : out_cnt_q;
        full_cyc_d = (byp_vld && !byp_rdy && (full_cyc_q != 32'hFFFF_FFFF)) ?
                     full_cyc_q + 32'd1 : full_cyc_q;
    end

    // Statistics registers.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            in_cnt_q   <= 32'd0;
            out_cnt_q  <= 32'd0;
            full_cyc_q <= 32'd0;
        end else begin
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            full_cyc_q <= full_cyc_d;
        end
    end
`endif

endmodule
